uart_rx_deser: RTL

UART receive deserializer sitting directly downstream of the `srx` serial input of the UART interface: it oversamples the asynchronous line, frames 8-bit characters (start, 8 data bits LSB first, optional parity, 1 stop bit) and buffers them in a small FIFO. It presents them on a valid/ready byte stream and drives `rts` for hardware flow control. It is the RTL counterpart the UVM receive-side agent drives and checks against.

---
 rtl/uart_rx_deser_if.sv | 25 ++
 rtl/uart_rx_deser.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser_if.sv
// uart_rx_deser_if: received-character byte stream (valid/ready) carrying the
// character at the FIFO head together with its framing and parity flags.
interface uart_rx_deser_if;
    logic [7:0] m_data;
    logic       m_ferr;
    logic       m_perr;
    logic       m_valid;
    logic       m_ready;

    modport master (
        output m_data,
        output m_ferr,
        output m_perr,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_ferr,
        input  m_perr,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 16x oversampling UART receiver. Frames start + 8 data bits
// (LSB first) + optional parity + 1 stop bit, buffers characters in a small
// FIFO, presents them on a valid/ready stream and drives rts flow control.
// Optional feature macro: UART_RX_PARITY_EN (adds the parity bit and m_perr).
module uart_rx_deser #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] divisor,
    input  logic             parity_odd,
    input  logic             srx,
    output logic             rts,
    uart_rx_deser_if.master  m,
    output logic             overrun,
    input  logic             err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_RX_PARITY_EN
    localparam int ENTRY_W = 10;
`else
    localparam int ENTRY_W = 9;
`endif
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   RTS_LIMIT  = (AW+1)'(FIFO_DEPTH-1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state_q, state_d;

    logic             sync1, sync2, line_prev;
    logic             fall;
    logic [DIV_W-1:0] div_q, div_eff, tick_cnt;
    logic             tick, sample_now;
    logic [3:0]       os;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic             push;
    logic             perr_bit;
    logic [ENTRY_W-1:0] entry, head;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic               pop, full, wr_en;

    // Line is idle high, so the synchronizer and edge history reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= srx;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    assign fall       = line_prev & ~sync2;
    assign div_eff    = (divisor == '0) ? DIV_W'(1) : divisor;
    assign tick       = (state_q != IDLE) && (tick_cnt == (div_q - DIV_W'(1)));
    assign sample_now = tick && (os == 4'd7);

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; push fires on the stop-bit mid-sample.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (sample_now) begin
                    state_d = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_now && (bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample_now) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (sample_now) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit timing and data capture: divisor latched and counters cleared on the start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            div_q    <= DIV_W'(1);
            os       <= 4'd0;
            bit_cnt  <= 3'd0;
            shift_q  <= 8'd0;
        end else if (state_q == IDLE) begin
            if (fall) begin
                tick_cnt <= '0;
                div_q    <= div_eff;
                os       <= 4'd0;
                bit_cnt  <= 3'd0;
            end
        end else begin
            if (tick) begin
                tick_cnt <= '0;
                os       <= os + 4'd1;
            end else begin
                tick_cnt <= tick_cnt + DIV_W'(1);
            end
            if (sample_now && (state_q == DATA)) begin
                shift_q <= {sync2, shift_q[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr_q;

    // Parity check: expected bit is the XOR of the data, inverted for odd parity.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (sample_now && (state_q == PARITY)) begin
            perr_q <= sync2 ^ (^shift_q) ^ parity_odd;
        end
    end

    assign perr_bit = perr_q;
    assign entry    = {perr_bit, ~sync2, shift_q};
    assign m.m_perr = head[9];
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign perr_bit = 1'b0;
    assign entry    = {~sync2, shift_q};
    assign m.m_perr = perr_bit;
`endif

    assign pop   = m.m_valid && m.m_ready;
    assign full  = (count == FULL_LEVEL);
    assign wr_en = push && (!full || pop);
    assign head  = mem[rd_ptr];

    // Receive FIFO, sticky overrun (set beats clear) and registered rts.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            rts     <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
            rts <= (count < RTS_LIMIT);
        end
    end

    assign m.m_valid = (count != '0);
    assign m.m_data  = head[7:0];
    assign m.m_ferr  = head[8];

endmodule
